wb_burst_reader: RTL

Wishbone master that fetches a block of consecutive 32-bit words from a Wishbone slave (typically the on-chip BlockRAM) using incrementing-address burst cycles, and delivers them in order on a valid/ready output stream. It is the initiator side of the memory bus. It feeds stream consumers (display, checksum, UART) from memory without a CPU in the loop. An internal FIFO absorbs downstream back-pressure. The block throttles the bus by dropping `stb`.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wshb_if.sv | 17 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/wb_burst_reader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared Wishbone master constants and reader state encoding.
// No logic; types and constants only.
// Not applicable (no handshake).
package wb_master_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 pipelined-less bus bundle (32-bit data, byte address).
// Wires only; latency set by the slave.
// Master throttles with stb, slave paces with ack.
interface wshb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_sm;
   logic        ack;

   modport master (output cyc, stb, we, adr, sel, cti, bte, input dat_sm, ack);
   modport slave  (input cyc, stb, we, adr, sel, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
// Push-to-output latency 1 cycle; pop is combinational on the head word.
// Pushes while full and pops while empty are dropped; caller must honour full/empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_dat,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Head word is presented directly; zero when empty so the output is defined.
   assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   // Pointer update; reset flushes the queue.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone burst reader: fetches len consecutive words into a valid/ready stream.
// Bus cycle starts the cycle after start; a word appears on out_* the cycle after its ack.
// Downstream stall fills the FIFO, which drops stb while holding adr for a clean restart.
module wb_burst_reader
   import wb_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   wshb_if.master               wb_m,
   input  logic                 start,
   input  logic [31:0]          base_adr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data
);

   rd_state_t            r_state;
   rd_state_t            w_state_nxt;
   logic [31:0]          r_adr_q;
   logic [31:0]          w_adr_nxt;
   logic [LEN_WIDTH-1:0] r_rem_q;
   logic [LEN_WIDTH-1:0] w_rem_nxt;
   logic                 r_zero_done;
   logic                 w_zero_done_nxt;

   logic                 w_cyc;
   logic                 w_stb;
   logic [2:0]           w_cti;
   logic                 w_done;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;

   // State and burst bookkeeping registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_adr_q     <= '0;
         r_rem_q     <= '0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_adr_q     <= w_adr_nxt;
         r_rem_q     <= w_rem_nxt;
         r_zero_done <= w_zero_done_nxt;
      end
   end

   // Next-state, bus drive and completion decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_adr_nxt       = r_adr_q;
      w_rem_nxt       = r_rem_q;
      w_zero_done_nxt = 1'b0;
      w_cyc           = 1'b0;
      w_stb           = 1'b0;
      w_cti           = CTI_CLASSIC;
      w_push          = 1'b0;
      w_done          = r_zero_done;

      case (r_state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_adr_nxt   = base_adr & 32'hFFFF_FFFC;
                  w_rem_nxt   = len;
                  w_state_nxt = BURST;
               end else begin
                  // Empty request completes without touching the bus.
                  w_zero_done_nxt = 1'b1;
               end
            end
         end
         BURST: begin
            w_cyc = 1'b1;
            // Never issue a beat that the FIFO could not take.
            w_stb = !w_fifo_full;
            w_cti = (r_rem_q == LEN_WIDTH'(1)) ? CTI_END : CTI_INCR;
            if (w_stb && wb_m.ack) begin
               w_push    = 1'b1;
               w_adr_nxt = r_adr_q + 32'd4;
               w_rem_nxt = r_rem_q - LEN_WIDTH'(1);
               if (r_rem_q == LEN_WIDTH'(1)) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_fifo_empty) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign wb_m.cyc = w_cyc;
   assign wb_m.stb = w_stb;
   assign wb_m.we  = 1'b0;
   assign wb_m.adr = r_adr_q;
   assign wb_m.sel = 4'hF;
   assign wb_m.cti = w_cti;
   assign wb_m.bte = BTE_LINEAR;

   assign busy      = (r_state != IDLE);
   assign done      = w_done;
   assign out_valid = !w_fifo_empty;
   assign w_pop     = out_valid && out_ready;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_push     (w_push),
      .i_push_dat (wb_m.dat_sm),
      .i_pop      (w_pop),
      .o_pop_dat  (out_data),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

endmodule
